// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
//
// Captures two WIDTH-bit operands and a carry-in on an accepted start.
// It then steps a single 1-bit full-adder cell LSB-first, one bit per clock.
// The carry between bit positions is held in a register.
// S/Cout are loaded only when the last bit has been processed, so partial sums
// are never visible on S.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..64)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset (clears control and datapath)
//   start  request, sampled only while idle
//   A, B   operands, captured on an accepted start
//   Cin    carry-in, captured on an accepted start
//   sub    subtract select (only when SERIAL_ADD_SUB_EN is defined)
//   S      result register, holds the last result
//   Cout   final carry, holds the last result
//   busy   high while an operation is in progress
//   done   one-cycle pulse in the cycle after S/Cout update
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   When defined, the sub port exists.
//   sub=1 computes A-B as A + ~B + 1, and Cin is ignored.
//   Cout=1 then means no borrow.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  // Holds the WIDTH-1 sum bits produced so far.
  // The final bit comes straight from the adder cell.
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_c;
  logic             accept, last_bit;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  // The single shared full-adder cell: returns {cout, s}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: invert B and force carry-in to 1.
  assign b_in = sub ? ~B : B;
  assign c_in = sub ? 1'b1 : Cin;
`else
  assign b_in = B;
  assign c_in = Cin;
`endif

  assign {fa_c, fa_s} = full_add(op_a[0], op_b[0], carry);
  assign sum_nxt      = {fa_s, sum_sr};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Operand capture, then one bit per clock.
  // The sum bit enters at the MSB, so after WIDTH steps bit 0 is the first bit computed.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      S      <= '0;
      Cout   <= 1'b0;
    end else if (accept) begin
      op_a  <= A;
      op_b  <= b_in;
      carry <= c_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a   <= op_a >> 1;
      op_b   <= op_b >> 1;
      carry  <= fa_c;
      sum_sr <= sum_nxt[WIDTH-1:1];
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        S    <= sum_nxt;
        Cout <= fa_c;
      end
    end
  end

endmodule
